// File: rtl/mem_access_unit.sv
// Memory access unit: runs one fetch/load/store transaction on a req/ack bus,
// owns the instruction register, aligns/extends load data and flags misaligned
// accesses and bus timeouts.
module mem_access_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            op_start,
    input  logic [1:0]      op_kind,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    output logic            busy,
    output logic            done,
    output logic            misalign,
    output logic            bus_err,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] load_data,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBus  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [1:0] KindFetch = 2'b00;
    localparam logic [1:0] KindLoad  = 2'b01;
    localparam logic [1:0] KindStore = 2'b10;
    localparam logic [1:0] KindRsvd  = 2'b11;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    // Counter just wide enough to reach the timeout limit
    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]   TmoLimit = TW'(ACK_TIMEOUT);
    localparam logic [XLEN-1:0] IrNop    = XLEN'(32'h0000_0013);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [1:0]      kind_q, kind_d;
    logic [1:0]      size_q, size_d;
    logic            sext_q, sext_d;
    logic            misalign_q, misalign_d;
    logic            bus_err_q, bus_err_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic [TW-1:0]   tmo_inc;
    logic            start_misalign;
    logic [XLEN-1:0] rdata_shifted;
    logic [XLEN-1:0] load_ext;

    assign tmo_inc       = tmo_q + TW'(1);
    assign rdata_shifted = mem_rdata >> {addr_q[1:0], 3'b000};

    // Classify a start request as misaligned/illegal (no bus cycle issued)
    always_comb begin
        start_misalign = 1'b0;
        if (op_kind == KindFetch) begin
            start_misalign = (addr[1:0] != 2'b00);
        end else begin
            case (size)
                SizeByte: start_misalign = 1'b0;
                SizeHalf: start_misalign = addr[0];
                SizeWord: start_misalign = (addr[1:0] != 2'b00);
                default:  start_misalign = 1'b1;
            endcase
        end
    end

    // Pick the addressed lanes out of the read word and extend them
    always_comb begin
        case (size_q)
            SizeByte: load_ext = {{(XLEN-8){sext_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
            SizeHalf: load_ext = {{(XLEN-16){sext_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default:  load_ext = rdata_shifted;
        endcase
    end

    // Next-state logic for the transaction FSM and its datapath registers
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        kind_d      = kind_q;
        size_d      = size_q;
        sext_d      = sext_q;
        misalign_d  = misalign_q;
        bus_err_d   = bus_err_q;
        ir_d        = ir_q;
        load_data_d = load_data_q;
        tmo_d       = tmo_q;
        case (state_q)
            StIdle: begin
                if (op_start && (op_kind != KindRsvd)) begin
                    addr_d     = addr;
                    wdata_d    = wdata;
                    kind_d     = op_kind;
                    size_d     = size;
                    sext_d     = sign_ext;
                    tmo_d      = '0;
                    bus_err_d  = 1'b0;
                    misalign_d = start_misalign;
                    state_d    = start_misalign ? StResp : StBus;
                end
            end
            StBus: begin
                // An ack always wins over a timeout landing in the same cycle
                if (mem_ack) begin
                    if (kind_q == KindFetch) begin
                        ir_d = mem_rdata;
                    end else if (kind_q == KindLoad) begin
                        load_data_d = load_ext;
                    end
                    state_d = StResp;
                end else if ((ACK_TIMEOUT != 0) && (tmo_inc == TmoLimit)) begin
                    tmo_d     = tmo_inc;
                    bus_err_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            kind_q      <= KindFetch;
            size_q      <= SizeByte;
            sext_q      <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            ir_q        <= IrNop;
            load_data_q <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            kind_q      <= kind_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            ir_q        <= ir_d;
            load_data_q <= load_data_d;
            tmo_q       <= tmo_d;
        end
    end

    // Byte enables: naturally sized lane group at the byte offset
    always_comb begin
        mem_be = 4'b0000;
        if (state_q == StBus) begin
            if (kind_q == KindFetch) begin
                mem_be = 4'b1111;
            end else begin
                case (size_q)
                    SizeByte: mem_be = 4'b0001 << addr_q[1:0];
                    SizeHalf: mem_be = 4'b0011 << addr_q[1:0];
                    default:  mem_be = 4'b1111;
                endcase
            end
        end
    end

    // Store data replicated across lanes so the slave can take any enabled lane
    always_comb begin
        mem_wdata = '0;
        if ((state_q == StBus) && (kind_q == KindStore)) begin
            case (size_q)
                SizeByte: mem_wdata = {(XLEN/8){wdata_q[7:0]}};
                SizeHalf: mem_wdata = {(XLEN/16){wdata_q[15:0]}};
                default:  mem_wdata = wdata_q;
            endcase
        end
    end

    // Status and bus control outputs decoded from state
    always_comb begin
        busy      = (state_q == StBus);
        done      = (state_q == StResp);
        misalign  = (state_q == StResp) && misalign_q;
        bus_err   = (state_q == StResp) && bus_err_q;
        mem_req   = (state_q == StBus);
        mem_we    = (state_q == StBus) && (kind_q == KindStore);
        mem_addr  = (state_q == StBus) ? {addr_q[XLEN-1:2], 2'b00} : '0;
        ir        = ir_q;
        load_data = load_data_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// transactions checked against a byte-level behavioural model.
module tb_mem_access_unit;

    localparam int unsigned TMO = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        op_start;
    logic [1:0]  op_kind;
    logic [1:0]  size;
    logic        sign_ext;
    logic        busy;
    logic        done;
    logic        misalign;
    logic        bus_err;
    logic [31:0] ir;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_ir;
    logic [31:0] exp_ld;

    mem_access_unit #(
        .XLEN        (32),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .op_start  (op_start),
        .op_kind   (op_kind),
        .size      (size),
        .sign_ext  (sign_ext),
        .busy      (busy),
        .done      (done),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .ir        (ir),
        .load_data (load_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one transaction from IDLE; starts and ends at a negedge in IDLE.
    task automatic run_op(input logic [1:0] kind, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic sx, input int waits,
                          input logic [31:0] rd, input bit give_ack);
        int          off;
        int          nb;
        int          bus_cycles;
        bit          mis;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_ld;
        logic [31:0] e_addr;

        off = int'(a[1:0]);
        nb  = (kind == 2'd0) ? 4 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (kind == 2'd0) mis = (off != 0);
        else mis = (sz == 2'd3) || ((off % nb) != 0);
        e_be = '0;
        e_wd = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) e_be[i] = 1'b1;
            if (kind == 2'd2) e_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        e_ld = '0;
        for (int i = 0; i < nb; i++) begin
            if (off + i < 4) e_ld[8*i +: 8] = rd[8*(off+i) +: 8];
        end
        if (sx && e_ld[8*nb-1]) begin
            for (int i = nb; i < 4; i++) e_ld[8*i +: 8] = 8'hFF;
        end
        e_addr     = {a[31:2], 2'b00};
        bus_cycles = give_ack ? waits + 1 : int'(TMO);

        op_start  = 1'b1;
        op_kind   = kind;
        size      = sz;
        addr      = a;
        wdata     = wd;
        sign_ext  = sx;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        step();
        addr     = $urandom;
        wdata    = $urandom;
        sign_ext = 1'($urandom_range(0, 1));
        size     = 2'($urandom_range(0, 3));
        op_start = 1'b0;
        mem_ack  = 1'b0;

        if (mis) begin
            check("mis_done", 32'(done), 32'd1);
            check("mis_flag", 32'(misalign), 32'd1);
            check("mis_buserr", 32'(bus_err), 32'd0);
            check("mis_req", 32'(mem_req), 32'd0);
            check("mis_busy", 32'(busy), 32'd0);
        end else begin
            for (int c = 1; c <= bus_cycles; c++) begin
                check("bus_req", 32'(mem_req), 32'd1);
                check("bus_busy", 32'(busy), 32'd1);
                check("bus_done", 32'(done), 32'd0);
                check("bus_we", 32'(mem_we), 32'(kind == 2'd2));
                check("bus_addr", mem_addr, e_addr);
                check("bus_be", 32'(mem_be), 32'(e_be));
                check("bus_wdata", mem_wdata, e_wd);
                // Start requests while busy must be dropped
                op_start  = 1'($urandom_range(0, 1));
                op_kind   = 2'($urandom_range(0, 2));
                mem_ack   = give_ack && (c == bus_cycles);
                mem_rdata = mem_ack ? rd : $urandom;
                step();
            end
            mem_ack  = 1'b0;
            op_start = 1'b0;
            if (give_ack) begin
                if (kind == 2'd0) exp_ir = rd;
                else if (kind == 2'd1) exp_ld = e_ld;
            end
            check("resp_done", 32'(done), 32'd1);
            check("resp_mis", 32'(misalign), 32'd0);
            check("resp_buserr", 32'(bus_err), 32'(!give_ack));
            check("resp_req", 32'(mem_req), 32'd0);
            check("resp_busy", 32'(busy), 32'd0);
        end
        check("ir", ir, exp_ir);
        check("load_data", load_data, exp_ld);

        // A start request presented during RESP is ignored
        op_start = 1'b1;
        op_kind  = 2'd0;
        addr     = 32'h0;
        mem_ack  = 1'($urandom_range(0, 1));
        step();
        op_start = 1'b0;
        mem_ack  = 1'b0;
        check("post_busy", 32'(busy), 32'd0);
        check("post_done", 32'(done), 32'd0);
        check("post_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        addr      = '0;
        wdata     = '0;
        op_start  = 1'b0;
        op_kind   = 2'd0;
        size      = 2'd0;
        sign_ext  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        exp_ir    = NOP;
        exp_ld    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ir", ir, NOP);
        check("rst_ld", load_data, 32'h0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        rst = 1'b1;
        step();

        // Fetch, ack in first bus cycle
        run_op(2'd0, 2'd0, 32'h100, 32'h0, 1'b0, 0, 32'h0050_0093, 1'b1);
        check("t1_ir", ir, 32'h0050_0093);

        // Byte load at lane 3 after three wait cycles, signed then unsigned
        run_op(2'd1, 2'd0, 32'h203, 32'h0, 1'b1, 3, 32'h80FF_1234, 1'b1);
        check("t2_ld_s", load_data, 32'hFFFF_FF80);
        run_op(2'd1, 2'd0, 32'h203, 32'h0, 1'b0, 3, 32'h80FF_1234, 1'b1);
        check("t2_ld_u", load_data, 32'h0000_0080);

        // Half store to upper half
        run_op(2'd2, 2'd1, 32'h42, 32'hDEAD_BEEF, 1'b0, 1, 32'h0, 1'b1);

        // Misaligned word load and misaligned fetch
        run_op(2'd1, 2'd2, 32'h301, 32'h0, 1'b0, 0, 32'h0, 1'b1);
        run_op(2'd0, 2'd0, 32'h2, 32'h0, 1'b0, 0, 32'h0, 1'b1);

        // Timeout with no ack
        run_op(2'd1, 2'd2, 32'h500, 32'h0, 1'b0, 0, 32'h0, 1'b0);

        // Reserved op_kind is ignored
        op_start = 1'b1;
        op_kind  = 2'd3;
        addr     = 32'h40;
        step();
        op_start = 1'b0;
        check("rsvd_busy", 32'(busy), 32'd0);
        check("rsvd_req", 32'(mem_req), 32'd0);
        step();
        check("rsvd_done", 32'(done), 32'd0);

        // Reset while a load waits on the bus
        op_start = 1'b1;
        op_kind  = 2'd1;
        size     = 2'd2;
        addr     = 32'h600;
        step();
        op_start = 1'b0;
        check("rb_req", 32'(mem_req), 32'd1);
        step();
        rst = 1'b0;
        step();
        exp_ir = NOP;
        exp_ld = '0;
        check("rb_req_drop", 32'(mem_req), 32'd0);
        check("rb_ir", ir, NOP);
        check("rb_ld", load_data, 32'h0);
        check("rb_done", 32'(done), 32'd0);
        check("rb_busy", 32'(busy), 32'd0);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        check("rb_late_done", 32'(done), 32'd0);
        check("rb_late_req", 32'(mem_req), 32'd0);
        check("rb_late_ld", load_data, 32'h0);
        step();

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  k;
            logic [1:0]  s;
            bit          ack;
            k   = 2'($urandom_range(0, 2));
            s   = 2'($urandom_range(0, 3));
            ack = ($urandom_range(0, 7) != 0);
            run_op(k, s, $urandom, $urandom, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), $urandom, ack);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
